cand_stream_fifo: RTL and testbench
===================================

// Module: cand_stream_fifo
// PURPOSE
//  Parametrised synchronous FIFO for 56-bit cracker candidate words, placed between generator and hash cores.
//  Handshake is valid/ready on both sides. Output is first-word-fall-through.
//  Provides a fill level, almost-full/almost-empty flags and a synchronous flush.
//  Flush lets a core drop queued candidates when a match is found.
// PARAMETERS
//  WIDTH      56   data word width in bits
//  DEPTH      256  number of entries; power of two, >= 4
//  AF_THRESH  240  almost_full asserted when level >= AF_THRESH
//  AE_THRESH  8    almost_empty asserted when level <= AE_THRESH
// PORTS
//  clk           in   1                    clock, rising edge
//  reset         in   1                    asynchronous, active-high reset
//  flush         in   1                    synchronous clear of all contents
//  in_data       in   WIDTH                write data
//  in_valid      in   1                    producer has a word
//  in_ready      out  1                    FIFO can accept a word
//  out_data      out  WIDTH                head-of-queue word
//  out_valid     out  1                    out_data holds a valid word
//  out_ready     in   1                    consumer takes the word
//  level         out  $clog2(DEPTH+1)      number of stored words
//  almost_full   out  1                    level >= AF_THRESH
//  almost_empty  out  1                    level <= AE_THRESH
//  overflow      out  1                    sticky: write attempted while full
//  underflow     out  1                    sticky: read attempted while empty
// BEHAVIOUR
//  - Reset is asynchronous, active-high, clock clk.
//    On reset: rd_ptr=0, wr_ptr=0, level=0, so in_ready=1, out_valid=0, almost_empty=1, almost_full=0, overflow=0, underflow=0.
//    Reset applies immediately at any point, including mid-burst. Stored data is discarded; array contents are not cleared.
//  - push = in_valid & in_ready. pop = out_valid & out_ready.
//  - in_ready = (level != DEPTH). There is no write-through when full; a pop in a full cycle frees the slot for the next cycle.
//  - out_valid = (level != 0). out_data = mem[rd_ptr], read combinationally.
//    A word written in cycle N is visible at the output in cycle N+1: 1-cycle latency.
//  - push only: mem[wr_ptr]<=in_data, wr_ptr+1, level+1.
//  - pop only: rd_ptr+1, level-1.
//  - push and pop together: both pointers advance and level is unchanged. This is legal at any level in 1..DEPTH-1.
//  - Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH with no special case.
//    level is tracked explicitly, so full and empty are unambiguous.
//  - flush=1: pointers and level return to 0 on the next edge. flush overrides any push or pop in the same cycle; those are dropped.
//  - Flags are combinational from level. No glitch constraint applies; they are sampled only on clk.
//  - No state machine: the block is a counter plus pointer pair.
// CONFIGURATION
//  - CAND_FIFO_ERR_EN defined:
//    overflow sets when in_valid & !in_ready. underflow sets when out_ready & !out_valid.
//    Both are sticky and cleared only by reset or flush. A flush cycle does not set them.
//  - CAND_FIFO_ERR_EN undefined: overflow and underflow are tied to 0, with no registers.
//  - Port list is identical in both configurations.
// STRUCTURE
//  - Package cand_pkg: CAND_W=56 constant, cand_t typedef (logic [CAND_W-1:0]) and default depth constant.
//  - One sub-module, cand_fifo_mem: DEPTH x WIDTH array, synchronous write, asynchronous read.
//    Kept separate so it can be swapped for a vendor RAM.
//  - Pointer, level and flag logic live in cand_stream_fifo.
// TESTING
//  1. Reset, then write 0x01..0x05 one per cycle with out_ready=0.
//     -> level=5; out_data=0x01 one cycle after the first write; almost_empty=1.
//  2. Fill with DEPTH=256 words.
//     -> in_ready=0 at level=256 and almost_full from level 240.
//     With ERR_EN, one more in_valid -> overflow=1 and level stays 256.
//  3. Run a continuous push+pop stream of 600 words at level 3.
//     -> pointers wrap twice, level holds 3 and the output order matches the input order.
//  4. At level 10, assert flush together with push and pop.
//     -> next cycle level=0, out_valid=0, in_ready=1; the pushed word is not stored.
//  5. Assert reset asynchronously mid-cycle during a burst.
//     -> outputs take their reset values before the next edge; a subsequent write of 0xAB reads back 0xAB first.
//  6. Empty FIFO, out_ready=1 for 3 cycles.
//     -> no pop and level=0. With ERR_EN underflow=1; a later flush clears it.

Source files
------------

// File: rtl/cand_pkg.sv
// Shared types and defaults for the candidate-word stream FIFO.
package cand_pkg;
  localparam int CAND_W         = 56;
  localparam int CAND_DEPTH     = 256;
  localparam int CAND_AF_THRESH = 240;
  localparam int CAND_AE_THRESH = 8;

  typedef logic [CAND_W-1:0] cand_t;
endpackage

// File: rtl/cand_fifo_mem.sv
// DEPTH x WIDTH storage: synchronous write, asynchronous read.
// Isolated so a vendor RAM with the same timing can drop in.
module cand_fifo_mem #(
  parameter int WIDTH = 56,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);
  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/cand_stream_fifo.sv
// First-word-fall-through candidate FIFO with level, threshold flags and flush.
// Define CAND_FIFO_ERR_EN to build the sticky overflow/underflow detectors.
module cand_stream_fifo
  import cand_pkg::*;
#(
  parameter int WIDTH     = CAND_W,
  parameter int DEPTH     = CAND_DEPTH,
  parameter int AF_THRESH = CAND_AF_THRESH,
  parameter int AE_THRESH = CAND_AE_THRESH,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LW-1:0]    level,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             overflow,
  output logic             underflow
);
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          w_push, w_pop, w_in_ready, w_out_valid;

  assign w_in_ready  = (r_level != LW'(DEPTH));
  assign w_out_valid = (r_level != '0);
  // flush wins: a same-cycle push or pop must not touch pointers or memory
  assign w_push = in_valid  & w_in_ready  & ~flush;
  assign w_pop  = out_ready & w_out_valid & ~flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  cand_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (in_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (out_data)
  );

  assign in_ready     = w_in_ready;
  assign out_valid    = w_out_valid;
  assign level        = r_level;
  assign almost_full  = (r_level >= LW'(AF_THRESH));
  assign almost_empty = (r_level <= LW'(AE_THRESH));

`ifdef CAND_FIFO_ERR_EN
  logic r_overflow, r_underflow;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (flush) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (in_valid  & ~w_in_ready)  r_overflow  <= 1'b1;
      if (out_ready & ~w_out_valid) r_underflow <= 1'b1;
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif
endmodule

// File: tb/tb_cand_stream_fifo.sv
// Scoreboard bench for cand_stream_fifo; follows CAND_FIFO_ERR_EN for flag expectations.
module tb_cand_stream_fifo;
  import cand_pkg::*;
  localparam int DEPTH = 256;
  localparam int AF    = 240;
  localparam int AE    = 8;
  localparam int LW    = $clog2(DEPTH+1);
`ifdef CAND_FIFO_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, flush, in_valid, out_ready;
  cand_t in_data, out_data;
  logic in_ready, out_valid, almost_full, almost_empty, overflow, underflow;
  logic [LW-1:0] level;

  always #5 clk = ~clk;

  cand_stream_fifo #(.WIDTH(CAND_W), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow)
  );

  int    n_tot = 0, n_bad = 0;
  int    m_lvl = 0;
  bit    m_ovf = 0, m_udf = 0;
  cand_t q[$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".lvl"}, 64'(level),        64'(m_lvl));
    chk({tag, ".ird"}, 64'(in_ready),     64'(m_lvl != DEPTH));
    chk({tag, ".ovl"}, 64'(out_valid),    64'(m_lvl != 0));
    chk({tag, ".af"},  64'(almost_full),  64'(m_lvl >= AF));
    chk({tag, ".ae"},  64'(almost_empty), 64'(m_lvl <= AE));
    chk({tag, ".ovf"}, 64'(overflow),     64'(ERR & m_ovf));
    chk({tag, ".udf"}, 64'(underflow),    64'(ERR & m_udf));
  endtask

  function automatic cand_t rnd();
    return cand_t'({$urandom, $urandom});
  endfunction

  // one clock cycle; entered and left just after a falling edge
  task automatic cyc(input bit iv, input cand_t din, input bit ordy, input bit fl);
    bit p, r;
    in_valid = iv; in_data = din; out_ready = ordy; flush = fl;
    #1;
    p = iv   && !fl && (m_lvl != DEPTH);
    r = ordy && !fl && (m_lvl != 0);
    if (r) begin
      chk("pop.data", 64'(out_data), 64'(q[0]));
      void'(q.pop_front());
    end
    if (p) q.push_back(din);
    if (!fl) begin
      if (iv && m_lvl == DEPTH) m_ovf = 1;
      if (ordy && m_lvl == 0)   m_udf = 1;
    end
    @(posedge clk);
    if (fl) begin
      q.delete(); m_lvl = 0; m_ovf = 0; m_udf = 0;
    end else begin
      m_lvl = m_lvl + int'(p) - int'(r);
    end
    @(negedge clk);
    in_valid = 0; out_ready = 0; flush = 0;
  endtask

  initial begin
    reset = 1; flush = 0; in_valid = 0; out_ready = 0; in_data = '0;
    repeat (2) @(negedge clk);
    chk_state("rst");
    reset = 0;

    // 1: five writes, consumer stalled
    cyc(1, cand_t'(1), 0, 0);
    chk("t1.head", 64'(out_data), 64'h1);
    chk("t1.ovl", 64'(out_valid), 64'h1);
    for (int i = 2; i <= 5; i++) cyc(1, cand_t'(i), 0, 0);
    chk_state("t1");
    chk("t1.lvl5", 64'(level), 64'd5);

    // 2: fill to full, attempt one extra write, drain
    for (int i = 5; i < DEPTH; i++) begin
      cyc(1, rnd(), 0, 0);
      chk_state("t2");
    end
    chk("t2.full_ird", 64'(in_ready), 64'h0);
    cyc(1, rnd(), 0, 0);
    chk_state("t2x");
    chk("t2x.lvl", 64'(level), 64'd256);
    for (int i = 0; i < DEPTH; i++) cyc(0, '0, 1, 0);
    chk_state("t2d");

    // 6: read while empty
    for (int i = 0; i < 3; i++) begin
      cyc(0, '0, 1, 0);
      chk_state("t6");
    end

    // 3: steady push+pop stream at level 3, pointers wrap
    for (int i = 0; i < 3; i++) cyc(1, rnd(), 0, 0);
    for (int i = 0; i < 600; i++) begin
      cyc(1, rnd(), 1, 0);
      chk("t3.lvl", 64'(level), 64'd3);
    end
    for (int i = 0; i < 3; i++) cyc(0, '0, 1, 0);
    chk_state("t3");

    // 4: flush with concurrent push and pop at level 10; also clears sticky flags
    for (int i = 0; i < 10; i++) cyc(1, rnd(), 0, 0);
    chk_state("t4a");
    cyc(1, cand_t'(56'h99), 1, 1);
    chk_state("t4");
    chk("t4.lvl0", 64'(level), 64'd0);
    chk("t4.udf0", 64'(underflow), 64'h0);
    cyc(1, cand_t'(56'h77), 0, 0);
    chk("t4.head", 64'(out_data), 64'h77);
    cyc(0, '0, 1, 0);

    // 5: asynchronous reset in the middle of a burst
    for (int i = 0; i < 4; i++) cyc(1, rnd(), 0, 0);
    in_valid = 1; in_data = rnd();
    @(posedge clk);
    #2 reset = 1;
    #1;
    q.delete(); m_lvl = 0; m_ovf = 0; m_udf = 0;
    chk_state("t5");
    @(negedge clk);
    in_valid = 0; reset = 0;
    cyc(1, cand_t'(56'hAB), 0, 0);
    chk("t5.head", 64'(out_data), 64'hAB);
    cyc(0, '0, 1, 0);
    chk_state("t5end");

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
